// File: rtl/maze_mem_arbiter_if.sv
// Maze cell memory arbiter bus: two requesters plus the memory port.
// slave = arbiter side, master = requesters/memory side.
interface maze_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 1
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/maze_mem_arbiter.sv
// Two-port arbiter onto the single-port maze cell memory.
// One outstanding access; round-robin or solver-priority.
module maze_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 1,
  parameter int MEM_LAT = 1,
  parameter bit PRIO_A  = 1'b0
) (
  input logic clk,
  input logic rst,
  maze_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t            state;
  state_t            state_nx;
  logic              owner;
  logic              pick;
  logic              any_req;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] a_rd;
  logic [DATA_W-1:0] b_rd;

  assign any_req = bus.a_req | bus.b_req;

  // winner selection: lone requester, else priority or the non-owner
  always_comb begin
    pick = bus.b_req;
    if (bus.a_req && bus.b_req)
      pick = PRIO_A ? 1'b0 : ~owner;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (any_req) state_nx = ISSUE;
      ISSUE: state_nx = lat_we ? RESP : WAIT;
      WAIT:  if (cnt == '0) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // grant latch, read-latency counter and per-port read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      a_rd      <= '0;
      b_rd      <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= pick;
        lat_we    <= pick ? bus.b_we    : bus.a_we;
        lat_addr  <= pick ? bus.b_addr  : bus.a_addr;
        lat_wdata <= pick ? bus.b_wdata : bus.a_wdata;
      end
      if (state == ISSUE)
        cnt <= CW'(MEM_LAT - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0) begin
        if (owner) b_rd <= bus.mem_rdata;
        else       a_rd <= bus.mem_rdata;
      end
    end
  end

  // outputs decoded from state and latches only
  always_comb begin
    bus.mem_en    = (state == ISSUE);
    bus.mem_we    = (state == ISSUE) & lat_we;
    bus.mem_addr  = lat_addr;
    bus.mem_wdata = lat_wdata;
    bus.a_ack     = (state == RESP) & ~owner;
    bus.b_ack     = (state == RESP) & owner;
    bus.a_rdata   = a_rd;
    bus.b_rdata   = b_rd;
    bus.busy      = (state != IDLE);
    bus.owner     = owner;
  end
endmodule
